mux4_case: RTL and testbench
============================

// Module: mux4_case
// PURPOSE
// - 4:1 multiplexer: routes one of four WIDTH-bit data inputs to the output, chosen by a 2-bit select.
// - Primary output `out` is purely combinational (zero latency).
// - A registered copy `out_q` and a capture flag are provided for synchronous consumers.
// - Generic datapath leaf used wherever a case-style 4-way data choice is needed.
// PARAMETERS
// - WIDTH  2  bit width of each data input and of out/out_q
// PORTS
// - clk          in   1      single clock; all state updates on rising edge
// - rst_n        in   1      reset, asynchronous, active-low
// - in0          in   WIDTH  data input, chosen when select==2'd0
// - in1          in   WIDTH  data input, chosen when select==2'd1
// - in2          in   WIDTH  data input, chosen when select==2'd2
// - in3          in   WIDTH  data input, chosen when select==2'd3
// - select       in   2      input choice
// - en           in   1      capture enable for out_q
// - out          out  WIDTH  combinational mux result
// - out_q        out  WIDTH  registered mux result
// - out_q_valid  out  1      high once out_q holds a captured value
// BEHAVIOUR
// - out: full case on select; 0->in0, 1->in1, 2->in2, 3->in3.
// - out: no latches, no clock dependency; settles within the same delta cycle as any input/select change.
// - out: if select contains X/Z, out = all-X (simulation only); no default-to-zero masking.
// - Reset (rst_n=0, asynchronous assert): out_q=0, out_q_valid=0 immediately, independent of clk.
// - Reset deassertion is synchronous-safe: first capture occurs on the first rising edge with rst_n=1 and en=1.
// - out: unaffected by reset; remains combinational during reset.
// - Rising clk, rst_n=1, en=1: out_q <= value of out at that edge; out_q_valid <= 1.
// - Rising clk, en=0: out_q and out_q_valid hold.
// - Latency: out = 0 cycles; out_q = 1 cycle after the sampled edge.
// - Select change coinciding with the clock edge: out_q captures the pre-edge (setup-time) value.
// - Reset asserted mid-operation: out_q/out_q_valid clear at once; resume per the rules above after release.
// - Width rule: all data paths exactly WIDTH bits; no extension or truncation.
// STRUCTURE
// - Shared package mux4_case_pkg: localparams SEL_IN0=2'd0, SEL_IN1=2'd1, SEL_IN2=2'd2, SEL_IN3=2'd3; typedef sel_t (logic [1:0]).
// - Sub-module mux4_case_core: pure combinational case mux (in0..in3, select -> out).
// - Top instantiates mux4_case_core and adds the out_q/out_q_valid register stage.
// TESTING (in0=2'b00, in1=2'b01, in2=2'b10, in3=2'b11, WIDTH=2)
// - Exhaustive select 0..3, 5 ns settle each -> out = 00, 01, 10, 11 respectively, no clock needed.
// - 100 random selects, 5 ns apart -> out equals case-model prediction every time; zero mismatches.
// - rst_n=0 with en=1, clocks running -> out_q=00, out_q_valid=0; out still follows select.
// - Release reset, en=1, select=2, one edge -> out_q=10, out_q_valid=1.
// - Next edges: en=0, select=3 -> out_q stays 10 while out=11.
// - Next edge: en=1 -> out_q=11.
// - Assert rst_n between edges while out_q=11 -> out_q=00 and out_q_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/mux4_case_pkg.sv
// ---------------------------------------------------------------------------
// mux4_case_pkg
// Shared definitions for the mux4_case slice: the select type and the
// named select encodings used by the case mux.
// ---------------------------------------------------------------------------
package mux4_case_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IN0 = 2'd0;
    localparam sel_t SEL_IN1 = 2'd1;
    localparam sel_t SEL_IN2 = 2'd2;
    localparam sel_t SEL_IN3 = 2'd3;

endpackage : mux4_case_pkg

// File: rtl/mux4_case_core.sv
// ---------------------------------------------------------------------------
// mux4_case_core
// Pure combinational 4:1 case multiplexer.
// Ports:
//   in0..in3 : WIDTH-bit data inputs, chosen by select 0..3
//   select   : 2-bit input choice
//   out      : WIDTH-bit mux result (zero latency)
// ---------------------------------------------------------------------------
module mux4_case_core
    import mux4_case_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out
);

    sel_t sel;
    assign sel = select;

    always_comb begin
        case (sel)
            SEL_IN0: out = in0;
            SEL_IN1: out = in1;
            SEL_IN2: out = in2;
            SEL_IN3: out = in3;
            // Only reachable with X/Z on select; propagate X rather than
            // masking it to zero so bad selects stay visible in simulation.
            default: out = 'x;
        endcase
    end

endmodule : mux4_case_core

// File: rtl/mux4_case.sv
// ---------------------------------------------------------------------------
// mux4_case
// 4:1 multiplexer with a combinational output and a registered copy.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset (clears out_q/out_q_valid)
//   in0..in3    : WIDTH-bit data inputs
//   select      : 2-bit input choice
//   en          : capture enable for out_q
//   out         : combinational mux result, unaffected by reset
//   out_q       : mux result captured on a rising edge with en=1
//   out_q_valid : high once out_q holds a captured value
// ---------------------------------------------------------------------------
module mux4_case
    import mux4_case_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       select,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_q_valid
);

    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    mux4_case_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .select (select),
        .out    (mux_out)
    );

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (en) begin
            data_d  = mux_out;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out         = mux_out;
    assign out_q       = data_q;
    assign out_q_valid = valid_q;

endmodule : mux4_case

// File: tb/tb_mux4_case.sv
// ---------------------------------------------------------------------------
// tb_mux4_case
// Self-checking bench for mux4_case (WIDTH=2). Expected values are pushed
// into scoreboard queues when stimulus is applied and popped when the DUT
// output is sampled.
// ---------------------------------------------------------------------------
module tb_mux4_case;

    localparam int unsigned WIDTH = 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in0, in1, in2, in3;
    logic [1:0]       select;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_q_valid;

    int unsigned n_tests;
    int unsigned n_fail;

    logic [WIDTH-1:0] comb_q[$];   // expected `out` values
    logic [WIDTH-1:0] reg_q[$];    // expected `out_q` values
    logic [WIDTH-1:0] tab [4];     // data value routed by each select
    logic [WIDTH-1:0] model_q;     // bench's own copy of the register

    mux4_case #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in0         (in0),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .select      (select),
        .en          (en),
        .out         (out),
        .out_q       (out_q),
        .out_q_valid (out_q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        in0 = a; in1 = b; in2 = c; in3 = d;
        tab[0] = a; tab[1] = b; tab[2] = c; tab[3] = d;
    endtask

    // Drive a select, queue its expected result, settle 5 ns, compare.
    task automatic comb_step(input string tag, input logic [1:0] s);
        select = s;
        comb_q.push_back(tab[s]);
        #5;
        if (comb_q.size() == 0) check({tag, "_empty"}, 1, 0);
        else check(tag, {30'd0, out}, {30'd0, comb_q.pop_front()});
    endtask

    // Sample out_q #1 after the next rising edge against the queued value.
    task automatic reg_step(input string tag);
        @(posedge clk);
        #1;
        if (reg_q.size() == 0) check({tag, "_empty"}, 1, 0);
        else check(tag, {30'd0, out_q}, {30'd0, reg_q.pop_front()});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        select  = 2'd0;
        set_inputs(2'b00, 2'b01, 2'b10, 2'b11);
        #2;

        // Exhaustive select, held in reset: out must not depend on it.
        for (int s = 0; s < 4; s++) comb_step("comb_exh", s[1:0]);

        // Random selects against the table.
        for (int i = 0; i < 100; i++) comb_step("comb_rand", 2'($urandom_range(0, 3)));

        // Random data as well, to cover every bit of each path.
        for (int i = 0; i < 20; i++) begin
            set_inputs(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            comb_step("comb_data", 2'($urandom_range(0, 3)));
        end
        set_inputs(2'b00, 2'b01, 2'b10, 2'b11);

        // Reset held with en=1 and clocks running.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_q", {30'd0, out_q}, 32'd0);
        check("rst_valid", {31'd0, out_q_valid}, 32'd0);
        comb_step("rst_comb", 2'd1);

        // Release, capture in2.
        @(negedge clk);
        rst_n  = 1'b1;
        en     = 1'b1;
        select = 2'd2;
        reg_q.push_back(tab[2]);
        model_q = tab[2];
        reg_step("cap_in2");
        check("cap_valid", {31'd0, out_q_valid}, 32'd1);

        // en=0: register holds while out follows select.
        @(negedge clk);
        en     = 1'b0;
        select = 2'd3;
        #1;
        check("hold_out", {30'd0, out}, {30'd0, tab[3]});
        repeat (2) begin
            reg_q.push_back(model_q);
            reg_step("hold_q");
        end
        check("hold_valid", {31'd0, out_q_valid}, 32'd1);

        // en=1 again: capture in3.
        @(negedge clk);
        en = 1'b1;
        reg_q.push_back(tab[3]);
        model_q = tab[3];
        reg_step("cap_in3");

        // Asynchronous reset between edges clears immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_q", {30'd0, out_q}, 32'd0);
        check("async_valid", {31'd0, out_q_valid}, 32'd0);
        check("async_out", {30'd0, out}, {30'd0, tab[3]});

        // Resume after release.
        @(negedge clk);
        rst_n  = 1'b1;
        select = 2'd1;
        reg_q.push_back(tab[1]);
        reg_step("resume_q");
        check("resume_valid", {31'd0, out_q_valid}, 32'd1);

        check("sb_drained", reg_q.size() + comb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux4_case
